// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative RV64M multiply/divide unit.
// Holds the default widths, the operation and state encodings, and the iteration count.
// Optional early-out behaviour is selected in muldiv_unit by MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

   localparam int unsigned DEF_XLEN    = 64;
   localparam int unsigned DEF_RADDR_W = 5;
   // One quotient/product bit per cycle; this must track the XLEN the unit is built with.
   localparam int unsigned ITER        = DEF_XLEN;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   // Divide family occupies the upper half of the opcode space.
   function automatic logic is_div_op(input op_t o);
      return o[2];
   endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: passes the value through, or negates it when en is set.
// Purely combinational, zero latency.
// No flow control; used for operand magnitudes and for the final result sign fix.
module muldiv_negate #(
   parameter int unsigned W = 64
) (
   input  logic         en,
   input  logic [W-1:0] val,
   output logic [W-1:0] res
);

   assign res = en ? (~val + 1'b1) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV64M multiply/divide stage writing its result into the register file.
// Latency: done in the cycle after edge N+65 (edge N+1 for zero-operand early-out with MULDIV_EARLY_OUT_EN).
// One operation in flight: start is only sampled in IDLE; requests while busy are ignored.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN    = DEF_XLEN,
   parameter int unsigned RADDR_W = DEF_RADDR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic [XLEN-1:0]    rs1_data,
   input  logic [XLEN-1:0]    rs2_data,
   input  logic [RADDR_W-1:0] rd_addr,
   output logic               busy,
   output logic               done,
   output logic               regwrite,
   output logic [RADDR_W-1:0] adr_wr_reg,
   output logic [XLEN-1:0]    wr_data
);

   localparam int unsigned CNT_W = $clog2(ITER + 1);

   state_t               state_q, state_d;
   op_t                  op_q, op_d;
   logic [RADDR_W-1:0]   rd_q, rd_d;
   logic [RADDR_W-1:0]   adr_q, adr_d;
   logic [XLEN-1:0]      a_q, a_d;          // raw dividend, returned by REM on divide-by-zero
   logic [XLEN-1:0]      m_q, m_d;          // multiplicand magnitude or divisor magnitude
   logic [XLEN-1:0]      hi_q, hi_d;        // product high half / partial remainder
   logic [XLEN-1:0]      lo_q, lo_d;        // multiplier-then-product low half / quotient
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 neg_q, neg_d;      // result needs negating
   logic                 zero_q, zero_d;    // mul operand zero, or divisor zero
   logic [XLEN-1:0]      wr_data_q, wr_data_d;

   // Operand decode, valid while IDLE for the incoming request.
   op_t                  op_in;
   logic                 sgn_a_en, sgn_b_en, neg_a, neg_b;
   logic [XLEN-1:0]      mag_a, mag_b;
   logic                 zero_in, neg_in;

   assign op_in    = op_t'(op);
   // MUL low bits are sign-agnostic, so only the high-half and signed divide ops take magnitudes.
   assign sgn_a_en = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   assign sgn_b_en = op_in inside {OP_MULH, OP_DIV, OP_REM};
   assign neg_a    = sgn_a_en & rs1_data[XLEN-1];
   assign neg_b    = sgn_b_en & rs2_data[XLEN-1];
   assign neg_in   = (op_in == OP_REM) ? neg_a : (neg_a ^ neg_b);
   assign zero_in  = is_div_op(op_in) ? (rs2_data == '0)
                                      : ((rs1_data == '0) || (rs2_data == '0));

   muldiv_negate #(.W(XLEN)) u_abs_a (.en(neg_a), .val(rs1_data), .res(mag_a));
   muldiv_negate #(.W(XLEN)) u_abs_b (.en(neg_b), .val(rs2_data), .res(mag_b));

   // Shift-add step: add multiplicand when the current multiplier bit is set, then shift the
   // 2*XLEN product right by one.
   logic [XLEN:0]   mul_sum;
   logic [XLEN-1:0] mul_hi, mul_lo;
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
   assign mul_hi  = mul_sum[XLEN:1];
   assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

   // Restoring step: shift in the next dividend bit and keep the subtraction if it did not borrow.
   logic [XLEN:0]   div_shift, div_trial;
   logic [XLEN-1:0] div_hi, div_lo;
   assign div_shift = {hi_q, lo_q[XLEN-1]};
   assign div_trial = div_shift - {1'b0, m_q};
   assign div_hi    = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
   assign div_lo    = {lo_q[XLEN-2:0], ~div_trial[XLEN]};

   // Sign correction over the full product width; divide results sit in the low half.
   logic [2*XLEN-1:0] fix_in, fix_out;
   logic [XLEN-1:0]   result;
   assign fix_in = is_div_op(op_q)
                 ? {{XLEN{1'b0}}, ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? lo_q : hi_q}
                 : {hi_q, lo_q};

   muldiv_negate #(.W(2*XLEN)) u_fix (.en(neg_q), .val(fix_in), .res(fix_out));

   // Result select, with the zero-operand and divide-by-zero overrides.
   always_comb begin
      result = fix_out[XLEN-1:0];
      case (op_q)
         OP_MUL:                       result = zero_q ? '0 : fix_out[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: result = zero_q ? '0 : fix_out[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              result = zero_q ? '1 : fix_out[XLEN-1:0];
         OP_REM, OP_REMU:              result = zero_q ? a_q : fix_out[XLEN-1:0];
         default:                      result = fix_out[XLEN-1:0];
      endcase
   end

   // Next-state and datapath update.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      adr_d     = adr_q;
      a_d       = a_q;
      m_d       = m_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      zero_d    = zero_q;
      wr_data_d = wr_data_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d   = op_in;
               rd_d   = rd_addr;
               a_d    = rs1_data;
               neg_d  = neg_in;
               zero_d = zero_in;
               hi_d   = '0;
               cnt_d  = '0;
               if (is_div_op(op_in)) begin
                  m_d     = mag_b;
                  lo_d    = mag_a;
                  state_d = ST_DIV;
               end else begin
                  m_d     = mag_a;
                  lo_d    = mag_b;
                  state_d = ST_MUL;
               end
            end
         end
         ST_MUL, ST_DIV: begin
            cnt_d = cnt_q + 1'b1;
            // First cycle after acceptance does no arithmetic; it is where early-out is decided.
            if (cnt_q == '0) begin
`ifdef MULDIV_EARLY_OUT_EN
               if (zero_q) state_d = ST_FIN;
`endif
            end else begin
               if (state_q == ST_MUL) begin
                  hi_d = mul_hi;
                  lo_d = mul_lo;
               end else begin
                  hi_d = div_hi;
                  lo_d = div_lo;
               end
               if (cnt_q == CNT_W'(ITER)) state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            wr_data_d = result;
            adr_d     = rd_q;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_MUL;
         rd_q      <= '0;
         adr_q     <= '0;
         a_q       <= '0;
         m_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         zero_q    <= 1'b0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         adr_q     <= adr_d;
         a_q       <= a_d;
         m_q       <= m_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         zero_q    <= zero_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Write port shows the live result in FIN and holds it afterwards.
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_FIN);
   assign regwrite   = done && (rd_q != '0);
   assign adr_wr_reg = done ? rd_q : adr_q;
   assign wr_data    = done ? result : wr_data_q;

endmodule
